// File: rtl/excp_commit_ctrl.sv
// -----------------------------------------------------------------------------
// excp_commit_ctrl
//
// Commits an exception or ERTN that reaches the WB stage. It latches the
// instruction's attributes, pulses the CSR write strobes for one cycle, holds
// a fetch redirect until fetch accepts it, and then waits until the younger
// pipeline stages have no exception left in flight before accepting new events.
//
// Optional feature: define EXCP_COMMIT_BADV_EN to write BADV on address-type
// exceptions. Without it, badv_we/badv_wdata are tied low and no BADV
// register exists.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   wb_valid/excp/ertn   WB stage instruction qualifiers
//   wb_ecode/esubcode    exception codes of the WB instruction
//   wb_pc, wb_badv       PC and faulting address of the WB instruction
//   csr_eentry, csr_era  redirect targets for exception / ERTN
//   pipe_excp_pending    exception flag still live in IF/ID/EX/ME
//   redirect_ready       fetch accepts the redirect
//   excp_commit          flush in progress (COMMIT or DRAIN)
//   redirect_valid/pc    fetch redirect request and target
//   era_we/wdata, estat_we/ecode/esubcode, ertn_restore, badv_we/wdata
//                        CSR update strobes and data
// -----------------------------------------------------------------------------
module excp_commit_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic              wb_excp,
  input  logic              wb_ertn,
  input  logic [5:0]        wb_ecode,
  input  logic [8:0]        wb_esubcode,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_badv,
  input  logic [ADDR_W-1:0] csr_eentry,
  input  logic [ADDR_W-1:0] csr_era,
  input  logic              pipe_excp_pending,
  input  logic              redirect_ready,
  output logic              excp_commit,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              era_we,
  output logic [ADDR_W-1:0] era_wdata,
  output logic              estat_we,
  output logic [5:0]        estat_ecode,
  output logic [8:0]        estat_esubcode,
  output logic              ertn_restore,
  output logic              badv_we,
  output logic [ADDR_W-1:0] badv_wdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              first_q;     // high only in the first COMMIT cycle
  logic              ertn_q;      // latched kind: 1 = ERTN, 0 = exception
  logic [5:0]        ecode_q;
  logic [8:0]        esubcode_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] target_q;

  logic wb_event;
  logic accept;

  // wb_valid gates both qualifiers; events are only taken while IDLE so a
  // flush in progress cannot be re-triggered by younger instructions.
  assign wb_event = wb_valid & (wb_excp | wb_ertn);
  assign accept   = (state_q == IDLE) & wb_event;

  // NOTE: every variable assigned here gets a default first, otherwise a
  // missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wb_event) state_d = COMMIT;
      COMMIT:  if (redirect_ready) state_d = DRAIN;
      DRAIN:   if (!pipe_excp_pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the attribute registers are reset as well as the state so that the
  // data outputs read 0 during and straight after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state always uses non-blocking assignments.
      state_q    <= IDLE;
      first_q    <= 1'b0;
      ertn_q     <= 1'b0;
      ecode_q    <= '0;
      esubcode_q <= '0;
      pc_q       <= '0;
      target_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= accept;
      if (accept) begin
        // Exception wins over a simultaneous ERTN.
        ertn_q     <= ~wb_excp;
        ecode_q    <= wb_ecode;
        esubcode_q <= wb_esubcode;
        pc_q       <= wb_pc;
        target_q   <= wb_excp ? csr_eentry : csr_era;
      end
    end
  end

  assign excp_commit    = (state_q == COMMIT) | (state_q == DRAIN);
  assign redirect_valid = (state_q == COMMIT);
  assign redirect_pc    = target_q;

  assign era_we         = (state_q == COMMIT) & first_q & ~ertn_q;
  assign estat_we       = era_we;
  assign ertn_restore   = (state_q == COMMIT) & first_q & ertn_q;
  assign era_wdata      = pc_q;
  assign estat_ecode    = ecode_q;
  assign estat_esubcode = esubcode_q;

`ifdef EXCP_COMMIT_BADV_EN
  logic [ADDR_W-1:0] badv_q;
  logic              badv_code;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badv_q <= '0;
    end else if (accept) begin
      badv_q <= wb_badv;
    end
  end

  // Address-type exceptions: PIL/PIS/PIF/PME, PPI, ADEF, ALE, TLBR.
  always_comb begin
    badv_code = 1'b0;
    unique case (ecode_q)
      6'h01, 6'h02, 6'h03, 6'h04,
      6'h07, 6'h08, 6'h09, 6'h3F: badv_code = 1'b1;
      default:                    badv_code = 1'b0;
    endcase
  end

  assign badv_we    = era_we & badv_code;
  assign badv_wdata = badv_q;
`else
  logic unused_badv;
  assign unused_badv = ^wb_badv;
  assign badv_we     = 1'b0;
  assign badv_wdata  = '0;
`endif

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_excp_commit_ctrl
//
// Directed bench for excp_commit_ctrl. Inputs change 1 ns after a rising edge
// and outputs are compared at that point, so each comparison sees the state
// that the preceding edge produced.
// -----------------------------------------------------------------------------
module tb_excp_commit_ctrl;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              resetn;
  logic              wb_valid, wb_excp, wb_ertn;
  logic [5:0]        wb_ecode;
  logic [8:0]        wb_esubcode;
  logic [ADDR_W-1:0] wb_pc, wb_badv, csr_eentry, csr_era;
  logic              pipe_excp_pending, redirect_ready;
  logic              excp_commit, redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              era_we, estat_we, ertn_restore, badv_we;
  logic [ADDR_W-1:0] era_wdata, badv_wdata;
  logic [5:0]        estat_ecode;
  logic [8:0]        estat_esubcode;

  int checks = 0;
  int errors = 0;

  excp_commit_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_valid          (wb_valid),
    .wb_excp           (wb_excp),
    .wb_ertn           (wb_ertn),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .wb_badv           (wb_badv),
    .csr_eentry        (csr_eentry),
    .csr_era           (csr_era),
    .pipe_excp_pending (pipe_excp_pending),
    .redirect_ready    (redirect_ready),
    .excp_commit       (excp_commit),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .era_we            (era_we),
    .era_wdata         (era_wdata),
    .estat_we          (estat_we),
    .estat_ecode       (estat_ecode),
    .estat_esubcode    (estat_esubcode),
    .ertn_restore      (ertn_restore),
    .badv_we           (badv_we),
    .badv_wdata        (badv_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_event(input logic excp, input logic ertn, input logic [5:0] ecode,
                             input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] badv);
    wb_valid    = 1'b1;
    wb_excp     = excp;
    wb_ertn     = ertn;
    wb_ecode    = ecode;
    wb_esubcode = 9'h005;
    wb_pc       = pc;
    wb_badv     = badv;
  endtask

  task automatic clear_event();
    wb_valid = 1'b0;
    wb_excp  = 1'b0;
    wb_ertn  = 1'b0;
  endtask

  initial begin
    resetn            = 1'b0;
    clear_event();
    wb_ecode          = '0;
    wb_esubcode       = '0;
    wb_pc             = '0;
    wb_badv           = '0;
    csr_eentry        = 32'h1C00_8000;
    csr_era           = 32'h1C00_0204;
    pipe_excp_pending = 1'b0;
    redirect_ready    = 1'b1;

    // Reset state
    #12;
    check("rst_commit", excp_commit, 0);
    check("rst_rvalid", redirect_valid, 0);
    check("rst_rpc", redirect_pc, 0);
    check("rst_era_we", era_we, 0);
    resetn = 1'b1;
    step();

    // wb_valid low: qualifiers ignored
    wb_excp = 1'b1;
    step();
    check("novalid_commit", excp_commit, 0);
    clear_event();

    // Basic exception: COMMIT, DRAIN, IDLE
    drive_event(1'b1, 1'b0, 6'h0B, 32'h1C00_0100, 32'hDEAD_0000);
    step();
    clear_event();
    check("ex_era_we", era_we, 1);
    check("ex_estat_we", estat_we, 1);
    check("ex_era_wdata", era_wdata, 32'h1C00_0100);
    check("ex_ecode", estat_ecode, 6'h0B);
    check("ex_esub", estat_esubcode, 9'h005);
    check("ex_rvalid", redirect_valid, 1);
    check("ex_rpc", redirect_pc, 32'h1C00_8000);
    check("ex_commit1", excp_commit, 1);
    check("ex_restore", ertn_restore, 0);
    check("ex_badv_we", badv_we, 0);
    step();
    check("ex_commit2", excp_commit, 1);
    check("ex_era_we2", era_we, 0);
    check("ex_rvalid2", redirect_valid, 0);
    step();
    check("ex_idle", excp_commit, 0);

    // ERTN taken in the first IDLE cycle after DRAIN
    drive_event(1'b0, 1'b1, 6'h00, 32'h1C00_0300, 32'h0);
    step();
    clear_event();
    check("ertn_restore", ertn_restore, 1);
    check("ertn_era_we", era_we, 0);
    check("ertn_estat_we", estat_we, 0);
    check("ertn_rpc", redirect_pc, 32'h1C00_0204);
    check("ertn_rvalid", redirect_valid, 1);
    step();
    check("ertn_restore2", ertn_restore, 0);
    check("ertn_drain", excp_commit, 1);
    step();
    check("ertn_idle", excp_commit, 0);

    // Redirect back-pressure for 4 cycles; targets change after latching
    redirect_ready = 1'b0;
    drive_event(1'b1, 1'b0, 6'h0B, 32'h1C00_0400, 32'h0);
    step();
    clear_event();
    check("bp_era_we", era_we, 1);
    csr_eentry = 32'h1234_5678;
    csr_era    = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_era_we_hold", era_we, 0);
      check("bp_rvalid", redirect_valid, 1);
      check("bp_rpc", redirect_pc, 32'h1C00_8000);
    end
    redirect_ready = 1'b1;
    step();
    check("bp_drain_rvalid", redirect_valid, 0);
    check("bp_drain_commit", excp_commit, 1);
    step();
    check("bp_idle", excp_commit, 0);

    // Pending exceptions hold DRAIN; a second event there is ignored
    csr_eentry = 32'h1C00_8000;
    csr_era    = 32'h1C00_0204;
    drive_event(1'b1, 1'b0, 6'h0B, 32'h1C00_0500, 32'h0);
    step();
    clear_event();
    pipe_excp_pending = 1'b1;
    check("dr_era_we", era_we, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive_event(1'b1, 1'b0, 6'h0C, 32'h1C00_0600, 32'h0);
      else clear_event();
      step();
      check("dr_commit", excp_commit, 1);
      check("dr_era_we0", era_we, 0);
      check("dr_rvalid", redirect_valid, 0);
    end
    clear_event();
    pipe_excp_pending = 1'b0;
    step();
    check("dr_idle", excp_commit, 0);
    check("dr_era_kept", era_wdata, 32'h1C00_0500);

    // Exception and ERTN together: exception wins
    redirect_ready = 1'b0;
    drive_event(1'b1, 1'b1, 6'h0B, 32'h1C00_0700, 32'h0);
    step();
    clear_event();
    check("both_era_we", era_we, 1);
    check("both_restore", ertn_restore, 0);
    check("both_rpc", redirect_pc, 32'h1C00_8000);

    // Reset in the middle of COMMIT clears everything at once
    #3;
    resetn = 1'b0;
    #1;
    check("mrst_commit", excp_commit, 0);
    check("mrst_rvalid", redirect_valid, 0);
    check("mrst_rpc", redirect_pc, 0);
    check("mrst_era_we", era_we, 0);
    check("mrst_era_wdata", era_wdata, 0);
    check("mrst_ecode", estat_ecode, 0);
    check("mrst_esub", estat_esubcode, 0);
    check("mrst_badv", badv_wdata, 0);
    redirect_ready = 1'b1;
    #2;
    resetn = 1'b1;

    // First edge after reset release accepts an event (ALE with BADV)
    drive_event(1'b1, 1'b0, 6'h09, 32'h1C00_0800, 32'h0000_0003);
    step();
    clear_event();
    check("ale_era_we", era_we, 1);
    check("ale_ecode", estat_ecode, 6'h09);
`ifdef EXCP_COMMIT_BADV_EN
    check("ale_badv_we", badv_we, 1);
    check("ale_badv_wdata", badv_wdata, 32'h0000_0003);
`else
    check("ale_badv_we", badv_we, 0);
    check("ale_badv_wdata", badv_wdata, 0);
`endif
    step();
    check("ale_badv_we2", badv_we, 0);
    step();
    check("ale_idle", excp_commit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
